fft_peak_search: RTL and testbench

- Sits between the FFT magnitude RAM (4096x16, filled by the RAM write controller) and the modulation-type detector.
- On a start pulse it scans a bin range of the RAM read port twice.
  - Pass 1 finds the largest spectral line.
  - Pass 2 finds the second-largest line outside a guard window around the first, and counts significant lines.
- The results are the carrier/sideband features the detector classifies on (CW / AM / FM / digital).

---
 rtl/fft_peak_search_pkg.sv | 22 ++
 rtl/fft_peak_search_if.sv | 35 +++
 rtl/fft_peak_search_sweeper.sv | 72 +++++++
 rtl/fft_peak_search.sv | 193 +++++++++++++++++++
 tb/tb_fft_peak_search.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_peak_search_pkg.sv
// Shared types and constants for the FFT peak-search block: FSM state encoding,
// default bus widths and the sig_count width helper.
package fft_feat_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    P1       = 3'd1,
    P1_DRAIN = 3'd2,
    P2       = 3'd3,
    P2_DRAIN = 3'd4,
    DONE     = 3'd5
  } state_t;

  // One extra bit so a count of every addressable bin still fits.
  function automatic int sig_cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fft_peak_search_if.sv
// Control, RAM read port and result bus of fft_peak_search.
// slave = the peak-search block, master = RAM model / detector side.
interface fft_peak_search_if #(
  parameter int ADDR_W = fft_feat_pkg::DEF_ADDR_W,
  parameter int DATA_W = fft_feat_pkg::DEF_DATA_W
);
  import fft_feat_pkg::*;

  localparam int SIG_W = sig_cnt_w(ADDR_W);

  logic                     start;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic                     busy;
  logic                     done;
  logic [DATA_W-1:0]        peak1_mag;
  logic [ADDR_W-1:0]        peak1_bin;
  logic [DATA_W-1:0]        peak2_mag;
  logic [ADDR_W-1:0]        peak2_bin;
  logic [SIG_W-1:0]         sig_count;
  logic [DATA_W+ADDR_W-1:0] floor_sum;

  modport slave (
    input  start, rd_data,
    output rd_addr, busy, done,
    output peak1_mag, peak1_bin, peak2_mag, peak2_bin, sig_count, floor_sum
  );

  modport master (
    output start, rd_data,
    input  rd_addr, busy, done,
    input  peak1_mag, peak1_bin, peak2_mag, peak2_bin, sig_count, floor_sum
  );

endinterface

// File: rtl/fft_peak_search_sweeper.sv
// Bin address sweeper: walks START_BIN..END_BIN once per load and delays a
// bin tag / valid / last flag by RD_LAT so each rd_data word arrives labelled.
module fft_bin_sweeper #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int START_BIN = 1,
  parameter int END_BIN   = 2047,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_issue_last,
  output logic [ADDR_W-1:0] o_bin,
  output logic [DATA_W-1:0] o_mag,
  output logic              o_valid,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_BIN);
  localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_BIN);

  logic [ADDR_W-1:0] r_cnt;
  logic              r_active;
  logic [ADDR_W-1:0] r_tag [RD_LAT];
  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_lst;
  logic              w_at_end;

  assign w_at_end = (r_cnt == END_A);

  // Counter stops on END_BIN and keeps it, so rd_addr holds while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= START_A;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (w_at_end) r_active <= 1'b0;
      else          r_cnt    <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
      r_vld <= '0;
      r_lst <= '0;
    end else begin
      r_tag[0] <= r_cnt;
      r_vld[0] <= r_active;
      r_lst[0] <= r_active && w_at_end;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
        r_vld[i] <= r_vld[i-1];
        r_lst[i] <= r_lst[i-1];
      end
    end
  end

  assign o_rd_addr    = r_cnt;
  assign o_issue_last = r_active && w_at_end;
  assign o_bin        = r_tag[RD_LAT-1];
  assign o_mag        = i_rd_data;
  assign o_valid      = r_vld[RD_LAT-1];
  assign o_last       = r_lst[RD_LAT-1];

endmodule

// File: rtl/fft_peak_search.sv
// Two-pass spectral peak search over the FFT magnitude RAM.
// Optional macro FFT_PEAK_FLOOR_EN builds the pass-1 magnitude accumulator (floor_sum).
//
// state    | meaning
// IDLE     | waiting for start, results held
// P1       | issuing pass-1 addresses (peak1 search)
// P1_DRAIN | collecting the last RD_LAT pass-1 reads
// P2       | issuing pass-2 addresses (peak2 search, significance count)
// P2_DRAIN | collecting the last RD_LAT pass-2 reads
// DONE     | latch results, pulse done
module fft_peak_search
  import fft_feat_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int START_BIN = 1,
  parameter int END_BIN   = 2047,
  parameter int GUARD     = 4,
  parameter int TH_SHIFT  = 3,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  fft_peak_search_if.slave  bus
);

  localparam int SIG_W = sig_cnt_w(ADDR_W);
  localparam int ACC_W = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_BIN);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_max1;
  logic [ADDR_W-1:0] r_bin1;
  logic [DATA_W-1:0] r_max2;
  logic [ADDR_W-1:0] r_bin2;
  logic [SIG_W-1:0]  r_sig;
  logic [DATA_W-1:0] r_peak1_mag;
  logic [ADDR_W-1:0] r_peak1_bin;
  logic [DATA_W-1:0] r_peak2_mag;
  logic [ADDR_W-1:0] r_peak2_bin;
  logic [SIG_W-1:0]  r_sig_count;

  logic              w_load;
  logic              w_issue_last;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_bin;
  logic [DATA_W-1:0] w_mag;
  logic              w_valid;
  logic              w_last;
  logic              w_pass1;
  logic              w_pass2;
  logic [ADDR_W-1:0] w_diff;
  logic [31:0]       w_diff32;
  logic              w_elig;
  logic [DATA_W-1:0] w_th;

  assign w_load  = ((r_state == IDLE) && bus.start) ||
                   ((r_state == P1_DRAIN) && w_last);
  assign w_pass1 = (r_state == P1) || (r_state == P1_DRAIN);
  assign w_pass2 = (r_state == P2) || (r_state == P2_DRAIN);

  fft_bin_sweeper #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .START_BIN (START_BIN),
    .END_BIN   (END_BIN),
    .RD_LAT    (RD_LAT)
  ) u_sweeper (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_rd_data    (bus.rd_data),
    .o_rd_addr    (w_rd_addr),
    .o_issue_last (w_issue_last),
    .o_bin        (w_bin),
    .o_mag        (w_mag),
    .o_valid      (w_valid),
    .o_last       (w_last)
  );

  // Order the subtraction so the distance never wraps; compare in 32 bits so
  // a GUARD wider than the address range simply excludes everything.
  assign w_diff   = (w_bin >= r_bin1) ? (w_bin - r_bin1) : (r_bin1 - w_bin);
  assign w_diff32 = 32'(w_diff);
  assign w_elig   = (w_diff32 > 32'(GUARD));
  assign w_th     = r_max1 >> TH_SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_max1      <= '0;
      r_bin1      <= '0;
      r_max2      <= '0;
      r_bin2      <= '0;
      r_sig       <= '0;
      r_peak1_mag <= '0;
      r_peak1_bin <= '0;
      r_peak2_mag <= '0;
      r_peak2_bin <= '0;
      r_sig_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= P1;
            r_busy  <= 1'b1;
            r_max1  <= '0;
            r_bin1  <= START_A;
          end
        end
        P1: begin
          if (w_issue_last) r_state <= P1_DRAIN;
        end
        P1_DRAIN: begin
          if (w_last) begin
            r_state <= P2;
            r_max2  <= '0;
            r_bin2  <= '0;
            r_sig   <= '0;
          end
        end
        P2: begin
          if (w_issue_last) r_state <= P2_DRAIN;
        end
        P2_DRAIN: begin
          if (w_last) r_state <= DONE;
        end
        DONE: begin
          r_peak1_mag <= r_max1;
          r_peak1_bin <= r_bin1;
          r_peak2_mag <= r_max2;
          r_peak2_bin <= r_bin2;
          r_sig_count <= r_sig;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // Strict compares keep the lowest bin on ties.
      if (w_valid && w_pass1) begin
        if (w_mag > r_max1) begin
          r_max1 <= w_mag;
          r_bin1 <= w_bin;
        end
      end

      if (w_valid && w_pass2) begin
        if (w_elig && (w_mag > r_max2)) begin
          r_max2 <= w_mag;
          r_bin2 <= w_bin;
        end
        if (w_mag > w_th) r_sig <= r_sig + SIG_W'(1);
      end
    end
  end

`ifdef FFT_PEAK_FLOOR_EN
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_floor;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_floor <= '0;
    end else begin
      if ((r_state == IDLE) && bus.start) r_acc <= '0;
      else if (w_valid && w_pass1)        r_acc <= r_acc + ACC_W'(w_mag);
      if (r_state == DONE) r_floor <= r_acc;
    end
  end

  assign bus.floor_sum = r_floor;
`else
  assign bus.floor_sum = '0;
`endif

  assign bus.rd_addr   = w_rd_addr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.peak1_mag = r_peak1_mag;
  assign bus.peak1_bin = r_peak1_bin;
  assign bus.peak2_mag = r_peak2_mag;
  assign bus.peak2_bin = r_peak2_bin;
  assign bus.sig_count = r_sig_count;

endmodule

// File: tb/tb_fft_peak_search.sv
// Scoreboard bench for fft_peak_search: three instances (full range RD_LAT=1,
// 1..15 RD_LAT=1, 1..255 RD_LAT=2) sharing one magnitude RAM image.
module tb_fft_peak_search;
  import fft_feat_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;
`ifdef FFT_PEAK_FLOOR_EN
  localparam bit FLR = 1'b1;
`else
  localparam bit FLR = 1'b0;
`endif

  typedef struct {
    int     p1m, p1b, p2m, p2b, sig;
    longint flr;
    int     lat;
    int     t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [0:4095];

  fft_peak_search_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  fft_peak_search_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();
  fft_peak_search_if #(.ADDR_W(AW), .DATA_W(DW)) bus_c ();

  fft_peak_search #(.ADDR_W(AW), .DATA_W(DW), .START_BIN(1), .END_BIN(2047),
                    .GUARD(4), .TH_SHIFT(3), .RD_LAT(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  fft_peak_search #(.ADDR_W(AW), .DATA_W(DW), .START_BIN(1), .END_BIN(15),
                    .GUARD(4), .TH_SHIFT(3), .RD_LAT(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  fft_peak_search #(.ADDR_W(AW), .DATA_W(DW), .START_BIN(1), .END_BIN(255),
                    .GUARD(4), .TH_SHIFT(3), .RD_LAT(2))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

  logic [DW-1:0] c_s1;
  always @(posedge clk) bus_a.rd_data <= mem[bus_a.rd_addr];
  always @(posedge clk) bus_b.rd_data <= mem[bus_b.rd_addr];
  always @(posedge clk) begin
    c_s1          <= mem[bus_c.rd_addr];
    bus_c.rd_data <= c_s1;
  end

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int   n_total = 0;
  int   n_pass  = 0;
  int   bc_a = 0, bc_b = 0, bc_c = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic check_done(input string tag, input exp_t e,
                            input logic [63:0] p1m, p1b, p2m, p2b, sig, flr,
                            input logic busy_now, input int bcnt);
    chk({tag, " peak1_mag"}, p1m, 64'(e.p1m));
    chk({tag, " peak1_bin"}, p1b, 64'(e.p1b));
    chk({tag, " peak2_mag"}, p2m, 64'(e.p2m));
    chk({tag, " peak2_bin"}, p2b, 64'(e.p2b));
    chk({tag, " sig_count"}, sig, 64'(e.sig));
    chk({tag, " floor_sum"}, flr, 64'(e.flr));
    chk({tag, " done_latency"}, 64'(cyc - e.t0), 64'(e.lat));
    chk({tag, " busy_in_done"}, 64'(busy_now), 64'd0);
    chk({tag, " busy_cycles"}, 64'(bcnt), 64'(e.lat - 1));
  endtask

  always @(negedge clk) begin
    if (rst) bc_a = 0;
    else if (bus_a.done) begin
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL a unexpected_done: got done=1, expected none");
      end else begin
        ea = qa.pop_front();
        check_done("a", ea, bus_a.peak1_mag, bus_a.peak1_bin, bus_a.peak2_mag,
                   bus_a.peak2_bin, bus_a.sig_count, bus_a.floor_sum, bus_a.busy, bc_a);
      end
      bc_a = 0;
    end else if (bus_a.busy) bc_a++;
  end

  always @(negedge clk) begin
    if (rst) bc_b = 0;
    else if (bus_b.done) begin
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL b unexpected_done: got done=1, expected none");
      end else begin
        eb = qb.pop_front();
        check_done("b", eb, bus_b.peak1_mag, bus_b.peak1_bin, bus_b.peak2_mag,
                   bus_b.peak2_bin, bus_b.sig_count, bus_b.floor_sum, bus_b.busy, bc_b);
      end
      bc_b = 0;
    end else if (bus_b.busy) bc_b++;
  end

  always @(negedge clk) begin
    if (rst) bc_c = 0;
    else if (bus_c.done) begin
      if (qc.size() == 0) begin
        n_total++;
        $display("FAIL c unexpected_done: got done=1, expected none");
      end else begin
        ec = qc.pop_front();
        check_done("c", ec, bus_c.peak1_mag, bus_c.peak1_bin, bus_c.peak2_mag,
                   bus_c.peak2_bin, bus_c.sig_count, bus_c.floor_sum, bus_c.busy, bc_c);
      end
      bc_c = 0;
    end else if (bus_c.busy) bc_c++;
  end

  function automatic exp_t mk(input int p1m, p1b, p2m, p2b, sig, input longint flr, input int lat);
    exp_t e;
    e.p1m = p1m; e.p1b = p1b; e.p2m = p2m; e.p2b = p2b; e.sig = sig;
    e.flr = FLR ? flr : 0;
    e.lat = lat;
    e.t0  = 0;
    return e;
  endfunction

  function automatic int qsize(input int w);
    case (w)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  // Start is raised for exactly one clock edge; push=0 issues a start with no
  // expected response (ignored or later aborted).
  task automatic do_start(input int w, input exp_t e, input bit push);
    @(negedge clk);
    e.t0 = cyc;
    case (w)
      0: begin bus_a.start = 1'b1; if (push) qa.push_back(e); end
      1: begin bus_b.start = 1'b1; if (push) qb.push_back(e); end
      default: begin bus_c.start = 1'b1; if (push) qc.push_back(e); end
    endcase
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    bus_c.start = 1'b0;
  endtask

  task automatic wait_q(input int w, input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      if (qsize(w) == 0) break;
      @(negedge clk);
    end
    if (n == budget) begin
      n_total++;
      $display("FAIL wait_done_%0d: got no done within %0d cycles, expected done", w, budget);
      case (w)
        0: qa.delete();
        1: qb.delete();
        default: qc.delete();
      endcase
    end
  endtask

  task automatic fill_mem(input logic [DW-1:0] v);
    for (int i = 0; i < 4096; i++) mem[i] = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    exp_t dummy;
    dummy = mk(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    bus_c.start = 1'b0;
    fill_mem('0);
    repeat (3) @(negedge clk);

    chk("reset rd_addr",   64'(bus_a.rd_addr),   64'd0);
    chk("reset busy",      64'(bus_a.busy),      64'd0);
    chk("reset done",      64'(bus_a.done),      64'd0);
    chk("reset peak1_mag", 64'(bus_a.peak1_mag), 64'd0);
    chk("reset peak1_bin", 64'(bus_a.peak1_bin), 64'd0);
    chk("reset sig_count", 64'(bus_a.sig_count), 64'd0);
    chk("reset floor_sum", 64'(bus_a.floor_sum), 64'd0);
    rst = 1'b0;

    // Edge/guard over bins 1..15: bin 3 inside guard of bin 1, bin 6 outside.
    mem[1] = 16'd9000; mem[3] = 16'd8000; mem[6] = 16'd100;
    do_start(1, mk(9000, 1, 100, 6, 2, 17100, 34), 1'b1);
    wait_q(1, 200);

    // Impulse with RD_LAT=2 over 1..255.
    fill_mem('0);
    mem[100] = 16'd5000;
    do_start(2, mk(5000, 100, 0, 0, 1, 5000, 516), 1'b1);
    wait_q(2, 1000);

    // Impulse over the full range.
    do_start(0, mk(5000, 100, 0, 0, 1, 5000, 4098), 1'b1);
    wait_q(0, 5000);

    // AM-like spectrum; extra starts while busy must be ignored.
    fill_mem(16'd10);
    mem[0]   = 16'd0;
    mem[200] = 16'd8000; mem[195] = 16'd2000;
    mem[205] = 16'd2000; mem[202] = 16'd7000;
    do_start(0, mk(8000, 200, 2000, 195, 4, 39430, 4098), 1'b1);
    repeat (20) @(negedge clk);
    do_start(0, dummy, 1'b0);
    repeat (2500) @(negedge clk);
    do_start(0, dummy, 1'b0);
    chk("held peak1_mag", 64'(bus_a.peak1_mag), 64'd5000);
    chk("held peak1_bin", 64'(bus_a.peak1_bin), 64'd100);
    chk("held sig_count", 64'(bus_a.sig_count), 64'd1);
    wait_q(0, 5000);
    repeat (3) @(negedge clk);
    chk("no queued start busy", 64'(bus_a.busy), 64'd0);

    // Reset during pass 2 aborts the scan with no done.
    fill_mem(16'd1);
    do_start(0, dummy, 1'b0);
    repeat (2100) @(negedge clk);
    chk("pre-abort busy", 64'(bus_a.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy",      64'(bus_a.busy),      64'd0);
    chk("abort done",      64'(bus_a.done),      64'd0);
    chk("abort peak1_mag", 64'(bus_a.peak1_mag), 64'd0);
    chk("abort peak2_bin", 64'(bus_a.peak2_bin), 64'd0);
    chk("abort sig_count", 64'(bus_a.sig_count), 64'd0);
    chk("abort rd_addr",   64'(bus_a.rd_addr),   64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort stays idle", 64'(bus_a.busy), 64'd0);

    // Fresh scan after abort: all bins = 1.
    do_start(0, mk(1, 1, 1, 6, 2047, 2047, 4098), 1'b1);
    wait_q(0, 5000);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
